piso_tx_sched: RTL and testbench
================================

Name: piso_tx_sched

Overview:
Two-requester transmit scheduler wrapped around a parallel-in serial-out shifter. It round-robin arbitrates between two parallel-word sources, loads the granted word into an internal shift register, and shifts it out MSB-first. It emits framing and completion strobes for the downstream serial sink. It sits between word producers and a single shared serial line, replacing manual load/shift sequencing.

Parameters:
WIDTH, 4, bits per word (legal range WIDTH >= 2)
CNT_W, 2, bit-counter width; must satisfy 2**CNT_W >= WIDTH

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
req0  input  1  requester 0 has a word pending; held until gnt0 seen
data0  input  WIDTH  requester 0 word; stable while req0 high
req1  input  1  requester 1 has a word pending; held until gnt1 seen
data1  input  WIDTH  requester 1 word; stable while req1 high
gnt0  output  1  one-cycle pulse: data0 captured
gnt1  output  1  one-cycle pulse: data1 captured
sout  output  1  serial data, MSB first; 0 when frame low
frame  output  1  high while sout carries a valid bit
busy  output  1  high in SHIFT state (equals frame)
done  output  1  one-cycle pulse in the cycle after the last bit of a word

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, shift_reg=0, bit_cnt=0, priority pointer selects req0. gnt0, gnt1, frame, busy and done all 0. sout=0.
- Reset mid-frame aborts immediately: the partial word is lost, no done pulse, and the pointer returns to req0.
- The FSM has two states, IDLE and SHIFT. All outputs are registered except sout. sout = shift_reg[WIDTH-1] AND frame.
- IDLE, rising edge with req0 or req1 high:
  - Select the winner by round-robin. If only one requester is active, it wins. If both are active, the one indicated by the pointer wins.
  - Load shift_reg with the winner's data.
  - Set bit_cnt to WIDTH-1, frame to 1 and the winner's gnt to 1.
  - Set the pointer to the other requester.
  - Move to SHIFT.
- IDLE with no request: hold, all strobes 0.
- SHIFT, each rising edge:
  - gnt0 and gnt1 go to 0, so each grant is exactly 1 cycle.
  - If bit_cnt != 0: shift shift_reg left by 1 with zero fill and decrement bit_cnt.
  - If bit_cnt == 0: frame goes to 0, done goes to 1, and the FSM moves to IDLE.
- done goes back to 0 on the following edge.
- Latency: the first bit appears in the cycle after the capture edge. frame is high for exactly WIDTH cycles per word.
- Minimum gap: frame is low for exactly 1 cycle (the done cycle) between back-to-back words. IDLE grants on the edge that ends the done cycle.
- Requests arriving during SHIFT are ignored until IDLE. They must remain asserted and are not lost.
- Requester protocol: a requester may drop req or change data on any edge after it sees its gnt high. Because each word lasts WIDTH >= 2 cycles, no double grant is possible.
- Pointer changes only on a grant, never on an idle cycle.
- gnt0 and gnt1 are never high together. done and frame are never high together.

Test Plan:
1. WIDTH=4, reset, then req0=1 with data0=1010 for one grant. Expect: gnt0 pulses 1 cycle; frame high 4 cycles with sout = 1,0,1,0; busy equals frame; done pulses in cycle 5; gnt1 stays 0.
2. After reset, req0 and req1 asserted on the same edge, data0=1010 and data1=0101, each dropped after its grant. Expect: gnt0 first, serial 1010, one-cycle gap with done=1, then gnt1 and serial 0101, then done.
3. req0 and req1 held high continuously. Expect: grants alternate 0,1,0,1; each frame lasts 4 cycles; exactly 1 frame-low cycle between frames.
4. req1 asserted at bit 2 of a req0 word. Expect: no gnt1 until the edge after done; then gnt1, frame high again, and sout = data1 MSB.
5. Drive reset_n low mid-frame (after 2 bits of 1010) without a clock edge. Expect: frame, sout, busy and done go to 0 immediately. After release with both requests high, gnt0 wins (pointer reset).
6. req1 alone, then req0 and req1 together. Expect: gnt1, then gnt0 first (pointer moved to 0), confirming that the pointer updates only on grants.

Source files
------------

// File: rtl/piso_tx_sched.sv
// Two-requester round-robin transmit scheduler feeding a MSB-first PISO shifter.
// Emits one-cycle grants, a frame qualifier over the serial bits and a done strobe.
module piso_tx_sched #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sout,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ptr;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_frame;
  logic             r_done;

  logic             w_pick1;
  logic [WIDTH-1:0] w_data;

  // r_ptr == 0 favours requester 0 when both are pending
  assign w_pick1 = req1 & (~req0 | r_ptr);
  assign w_data  = w_pick1 ? data1 : data0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_ptr   <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_frame <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
          if (req0 || req1) begin
            r_shift <= w_data;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_frame <= 1'b1;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            r_ptr   <= ~w_pick1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_gnt0 <= 1'b0;
          r_gnt1 <= 1'b0;
          if (r_cnt != '0) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - CNT_W'(1);
          end else begin
            r_frame <= 1'b0;
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign frame = r_frame;
  assign busy  = (r_state == SHIFT);
  assign done  = r_done;
  assign sout  = r_shift[WIDTH-1] & r_frame;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Self-checking bench for piso_tx_sched: queue-based serial-line model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_piso_tx_sched;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1, sout, frame, busy, done;

  int n_total = 0;
  int n_pass  = 0;

  piso_tx_sched #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .sout(sout), .frame(frame), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: the line is a queue of pending bits; each edge consumes one bit,
  // and an empty line at an edge is where arbitration happens.
  bit m_q[$];
  bit m_ptr, m_gnt0, m_gnt1, m_done;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_ptr = 0; m_gnt0 = 0; m_gnt1 = 0; m_done = 0;
    end else begin
      m_gnt0 = 0; m_gnt1 = 0;
      if (m_q.size() != 0) begin
        void'(m_q.pop_front());
        m_done = (m_q.size() == 0);
      end else begin
        m_done = 0;
        if (req0 || req1) begin
          bit win1;
          logic [WIDTH-1:0] d;
          win1 = (req1 && !req0) || (req0 && req1 && m_ptr);
          d = win1 ? data1 : data0;
          for (int i = WIDTH - 1; i >= 0; i--) m_q.push_back(d[i]);
          m_gnt0 = !win1; m_gnt1 = win1;
          m_ptr = !win1;
        end
      end
    end
  end

  // Observation log used by literal checks
  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] words_q[$];
  int               gnt_q[$];
  int               gap_q[$];
  int               low_cnt;
  bit               seen_frame;

  task automatic clear_log();
    words_q.delete(); gnt_q.delete(); gap_q.delete();
    low_cnt = 0; seen_frame = 0; cur_word = '0;
  endtask

  always @(negedge clock) begin
    bit e_frame, e_sout;
    e_frame = (m_q.size() != 0);
    e_sout  = e_frame ? m_q[0] : 1'b0;
    chk("gnt0", 32'(gnt0), 32'(m_gnt0));
    chk("gnt1", 32'(gnt1), 32'(m_gnt1));
    chk("frame", 32'(frame), 32'(e_frame));
    chk("busy", 32'(busy), 32'(e_frame));
    chk("sout", 32'(sout), 32'(e_sout));
    chk("done", 32'(done), 32'(m_done));
    chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
    chk("done_frame_excl", 32'(done & frame), 32'd0);
    if (gnt0) gnt_q.push_back(0);
    if (gnt1) gnt_q.push_back(1);
    if (frame) begin
      if (gnt0 || gnt1) begin
        if (seen_frame) gap_q.push_back(low_cnt);
        cur_word = WIDTH'(sout);
      end else begin
        cur_word = {cur_word[WIDTH-2:0], sout};
      end
      seen_frame = 1; low_cnt = 0;
    end else begin
      low_cnt++;
    end
    if (done) words_q.push_back(cur_word);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
    tick(2);
    reset_n = 1'b1;
    clear_log();
  endtask

  // Drop each request once its grant has been seen
  task automatic run_drop(input int n);
    repeat (n) begin
      tick(1);
      if (gnt0) req0 = 0;
      if (gnt1) req1 = 0;
    end
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!done && k < 20) begin tick(1); k++; end
    if (!done) chk(nm, 32'd0, 32'd1);
  endtask

  initial begin
    reset_n = 1'b0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
    clear_log();
    tick(1);
    chk("rst_outs", {26'd0, gnt0, gnt1, sout, frame, busy, done}, 32'd0);
    do_reset();

    // 1: single word from requester 0
    req0 = 1; data0 = 4'b1010;
    run_drop(8);
    chk("t1_words", 32'(words_q.size()), 32'd1);
    if (words_q.size() > 0) chk("t1_word", 32'(words_q[0]), 32'b1010);
    chk("t1_gnts", 32'(gnt_q.size()), 32'd1);

    // 2: simultaneous requests, pointer at 0
    do_reset();
    req0 = 1; data0 = 4'b1010; req1 = 1; data1 = 4'b0101;
    run_drop(14);
    chk("t2_words", 32'(words_q.size()), 32'd2);
    if (words_q.size() >= 2) begin
      chk("t2_word0", 32'(words_q[0]), 32'b1010);
      chk("t2_word1", 32'(words_q[1]), 32'b0101);
    end
    if (gnt_q.size() >= 2) begin
      chk("t2_gnt_first", 32'(gnt_q[0]), 32'd0);
      chk("t2_gnt_second", 32'(gnt_q[1]), 32'd1);
    end
    if (gap_q.size() >= 1) chk("t2_gap", 32'(gap_q[0]), 32'd1);

    // 3: both held continuously, four grants
    do_reset();
    req0 = 1; data0 = 4'b1100; req1 = 1; data1 = 4'b0011;
    begin
      int k;
      k = 0;
      while (gnt_q.size() < 4 && k < 40) begin tick(1); k++; end
      req0 = 0; req1 = 0;
    end
    tick(6);
    chk("t3_ngnt", 32'(gnt_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < gnt_q.size(); i++)
      chk($sformatf("t3_gnt%0d", i), 32'(gnt_q[i]), 32'(i % 2));
    chk("t3_ngap", 32'(gap_q.size()), 32'd3);
    foreach (gap_q[i]) chk($sformatf("t3_gap%0d", i), 32'(gap_q[i]), 32'd1);
    if (words_q.size() >= 2) chk("t3_word1", 32'(words_q[1]), 32'b0011);

    // 4: req1 arrives mid-word; granted on the edge ending the done cycle
    do_reset();
    req0 = 1; data0 = 4'b1010;
    run_drop(2);
    req1 = 1; data1 = 4'b1001;
    wait_done("t4_done_timeout");
    chk("t4_no_gnt1_in_done", 32'(gnt1), 32'd0);
    tick(1);
    chk("t4_gnt1", 32'(gnt1), 32'd1);
    chk("t4_frame", 32'(frame), 32'd1);
    chk("t4_sout_msb", 32'(sout), 32'd1);
    req1 = 0;
    tick(6);

    // 5: asynchronous reset mid-frame
    do_reset();
    req0 = 1; data0 = 4'b1010;
    run_drop(3);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_clear", {28'd0, frame, sout, busy, done}, 32'd0);
    req0 = 1; data0 = 4'b1010; req1 = 1; data1 = 4'b0101;
    reset_n = 1'b1;
    clear_log();
    tick(1);
    chk("t5_gnt0_after_rst", 32'(gnt0), 32'd1);
    chk("t5_gnt1_after_rst", 32'(gnt1), 32'd0);
    req0 = 0;
    run_drop(12);

    // 6: pointer moves only on grants, not on idle cycles
    do_reset();
    req1 = 1; data1 = 4'b0110;
    tick(1);
    chk("t6_gnt1", 32'(gnt1), 32'd1);
    req1 = 0;
    tick(10);
    req0 = 1; data0 = 4'b1110; req1 = 1; data1 = 4'b0111;
    tick(1);
    chk("t6_gnt0_first", 32'(gnt0), 32'd1);
    req0 = 0;
    run_drop(12);
    chk("t6_words", 32'(words_q.size()), 32'd3);
    if (words_q.size() >= 3) begin
      chk("t6_word0", 32'(words_q[0]), 32'b0110);
      chk("t6_word1", 32'(words_q[1]), 32'b1110);
      chk("t6_word2", 32'(words_q[2]), 32'b0111);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
